// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard front end: sync, clock filter, frame FSM, prefix decode.
// Emits one-cycle snake direction and start pulses.
module ps2_key_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic       userStart,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                r_state;
  logic                  r_clk_s1;
  logic                  r_clk_s2;
  logic                  r_dat_s1;
  logic                  r_dat_s2;
  logic [FILTER_LEN-1:0] r_filt;
  logic                  r_fclk;
  logic [2:0]            r_bcnt;
  logic [7:0]            r_shift;
  logic                  r_par;
  logic [TW-1:0]         r_to;
  logic                  r_ext;
  logic                  r_brk;

  logic w_fall;
  logic w_timeout;
  logic w_ok;
  logic w_up;
  logic w_down;
  logic w_left;
  logic w_right;
  logic w_start;

  assign w_fall    = r_fclk & ~|r_filt;
  assign w_timeout = (r_state != S_IDLE) && !w_fall &&
                     (r_to == TW'(TIMEOUT_CYCLES - 1));
  // Stop must be 1 and data+parity must carry odd ones.
  assign w_ok      = r_dat_s2 & (^{r_shift, r_par});

  always_comb begin
    w_up    = 1'b0;
    w_down  = 1'b0;
    w_left  = 1'b0;
    w_right = 1'b0;
    w_start = 1'b0;
    if (!r_brk) begin
      unique case (1'b1)
        r_ext && r_shift == 8'h75:  w_up    = 1'b1;
        r_ext && r_shift == 8'h72:  w_down  = 1'b1;
        r_ext && r_shift == 8'h6B:  w_left  = 1'b1;
        r_ext && r_shift == 8'h74:  w_right = 1'b1;
        !r_ext && r_shift == 8'h1D: w_up    = 1'b1;
        !r_ext && r_shift == 8'h1B: w_down  = 1'b1;
        !r_ext && r_shift == 8'h1C: w_left  = 1'b1;
        !r_ext && r_shift == 8'h23: w_right = 1'b1;
        !r_ext && r_shift == 8'h5A: w_start = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
      r_filt     <= '1;
      r_fclk     <= 1'b1;
      r_state    <= S_IDLE;
      r_bcnt     <= '0;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_to       <= '0;
      r_ext      <= 1'b0;
      r_brk      <= 1'b0;
      up         <= 1'b0;
      down       <= 1'b0;
      left       <= 1'b0;
      right      <= 1'b0;
      userStart  <= 1'b0;
      scan_code  <= 8'h00;
      scan_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      r_clk_s1   <= ps2_clk;
      r_clk_s2   <= r_clk_s1;
      r_dat_s1   <= ps2_data;
      r_dat_s2   <= r_dat_s1;
      r_filt     <= {r_filt[FILTER_LEN-2:0], r_clk_s2};
      if (~|r_filt)
        r_fclk <= 1'b0;
      else if (&r_filt)
        r_fclk <= 1'b1;

      up         <= 1'b0;
      down       <= 1'b0;
      left       <= 1'b0;
      right      <= 1'b0;
      userStart  <= 1'b0;
      scan_valid <= 1'b0;
      frame_err  <= 1'b0;

      if (w_fall)
        r_to <= '0;
      else if (r_state != S_IDLE && !w_timeout)
        r_to <= r_to + 1'b1;

      if (w_timeout) begin
        r_state   <= S_IDLE;
        r_to      <= '0;
        r_ext     <= 1'b0;
        r_brk     <= 1'b0;
        frame_err <= 1'b1;
      end else if (w_fall) begin
        unique case (r_state)
          S_IDLE: begin
            if (!r_dat_s2) begin
              r_state <= S_DATA;
              r_bcnt  <= '0;
            end else begin
              frame_err <= 1'b1;
            end
          end
          S_DATA: begin
            r_shift <= {r_dat_s2, r_shift[7:1]};
            r_bcnt  <= r_bcnt + 1'b1;
            if (r_bcnt == 3'd7)
              r_state <= S_PARITY;
          end
          S_PARITY: begin
            r_par   <= r_dat_s2;
            r_state <= S_STOP;
          end
          S_STOP: begin
            r_state <= S_IDLE;
            if (w_ok) begin
              scan_code  <= r_shift;
              scan_valid <= 1'b1;
              if (r_shift == 8'hE0) begin
                r_ext <= 1'b1;
              end else if (r_shift == 8'hF0) begin
                r_brk <= 1'b1;
              end else begin
                up        <= w_up;
                down      <= w_down;
                left      <= w_left;
                right     <= w_right;
                userStart <= w_start;
                r_ext     <= 1'b0;
                r_brk     <= 1'b0;
              end
            end else begin
              frame_err <= 1'b1;
              r_ext     <= 1'b0;
              r_brk     <= 1'b0;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: directed and random PS/2 frames
// checked against an event-queue model of the key decoder.
module tb_ps2_key_decoder;

  localparam int FL = 8;
  localparam int TO = 1000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       up, down, left, right, userStart;
  logic [7:0] scan_code;
  logic       scan_valid, frame_err;

  ps2_key_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .up(up), .down(down), .left(left), .right(right),
    .userStart(userStart), .scan_code(scan_code),
    .scan_valid(scan_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic       err;
    logic [7:0] code;
    logic [4:0] cmd;
  } ev_t;

  ev_t        q[$];
  int         checks = 0;
  int         errors = 0;
  longint     cyc = 0;
  longint     last_pulse = 0;
  logic [4:0] last_cmd = 5'd0;
  logic [7:0] m_code = 8'h00;
  logic       m_ext = 1'b0;
  logic       m_brk = 1'b0;
  bit         chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : cmp
    logic [4:0] c;
    ev_t        e;
    if (chk_en) begin
      if (rst) begin
        m_code = 8'h00;
      end else begin
        c = {up, down, left, right, userStart};
        check("one_hot_cmd", 32'($countones(c) <= 1), 32'd1);
        if (c != 0 || scan_valid || frame_err) begin
          last_pulse = cyc;
          if (q.size() == 0) begin
            check("unexpected_pulse", {25'd0, scan_valid, frame_err, c}, 32'd0);
          end else begin
            e = q.pop_front();
            check("scan_valid", 32'(scan_valid), 32'(e.valid));
            check("frame_err", 32'(frame_err), 32'(e.err));
            check("cmd", 32'(c), 32'(e.cmd));
            if (e.valid) begin
              m_code   = e.code;
              last_cmd = e.cmd;
            end
          end
        end
        check("scan_code", 32'(scan_code), 32'(m_code));
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_byte(input logic [7:0] b, output logic [4:0] cmd);
    cmd = 5'd0;
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      if (!m_brk) begin
        if (m_ext) begin
          case (b)
            8'h75: cmd = 5'b10000;
            8'h72: cmd = 5'b01000;
            8'h6B: cmd = 5'b00100;
            8'h74: cmd = 5'b00010;
            default: cmd = 5'd0;
          endcase
        end else begin
          case (b)
            8'h1D: cmd = 5'b10000;
            8'h1B: cmd = 5'b01000;
            8'h1C: cmd = 5'b00100;
            8'h23: cmd = 5'b00010;
            8'h5A: cmd = 5'b00001;
            default: cmd = 5'd0;
          endcase
        end
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic clk_pulse(input logic d, input int hp);
    ps2_data = d;
    wait_cyc(hp);
    ps2_clk = 1'b0;
    wait_cyc(hp);
    ps2_clk = 1'b1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 300 && q.size() != 0; i++) wait_cyc(1);
    check({"drain_", name}, 32'(q.size()), 32'd0);
  endtask

  // Full 11-bit frame; the expected event is queued at the stop-bit edge.
  task automatic send_frame(input logic [7:0] b, input bit bad_par,
                            input bit bad_stop, input int hp,
                            output longint stop_fall);
    logic [4:0] c;
    ev_t        e;
    logic       par;
    par = ~(^b) ^ bad_par;
    clk_pulse(1'b0, hp);
    for (int i = 0; i < 8; i++) clk_pulse(b[i], hp);
    clk_pulse(par, hp);
    ps2_data = !bad_stop;
    wait_cyc(hp);
    if (!bad_par && !bad_stop) begin
      model_byte(b, c);
      e.valid = 1'b1; e.err = 1'b0; e.code = b; e.cmd = c;
    end else begin
      m_ext = 1'b0; m_brk = 1'b0;
      e.valid = 1'b0; e.err = 1'b1; e.code = 8'h00; e.cmd = 5'd0;
    end
    q.push_back(e);
    ps2_clk = 1'b0;
    stop_fall = cyc;
    wait_cyc(hp);
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(2 * hp);
  endtask

  task automatic good(input logic [7:0] b, input int hp, input string name);
    longint sf;
    longint lat;
    send_frame(b, 1'b0, 1'b0, hp, sf);
    drain(name);
    lat = last_pulse - sf;
    check({"latency_", name}, 32'(lat >= FL + 2 && lat <= FL + 4), 32'd1);
  endtask

  task automatic partial_timeout(input int nbits, input int hp);
    ev_t    e;
    longint lf;
    longint lat;
    clk_pulse(1'b0, hp);
    lf = cyc - hp;
    for (int i = 1; i < nbits; i++) begin
      clk_pulse(1'($urandom_range(0, 1)), hp);
      lf = cyc - hp;
    end
    ps2_data = 1'b1;
    m_ext = 1'b0; m_brk = 1'b0;
    e.valid = 1'b0; e.err = 1'b1; e.code = 8'h00; e.cmd = 5'd0;
    q.push_back(e);
    wait_cyc(TO + 60);
    drain("timeout");
    lat = last_pulse - lf;
    check("timeout_latency",
          32'(lat >= TO + FL && lat <= TO + FL + 6), 32'd1);
  endtask

  task automatic bad_start(input int hp);
    ev_t e;
    e.valid = 1'b0; e.err = 1'b1; e.code = 8'h00; e.cmd = 5'd0;
    ps2_data = 1'b1;
    wait_cyc(hp);
    q.push_back(e);
    ps2_clk = 1'b0;
    wait_cyc(hp);
    ps2_clk = 1'b1;
    wait_cyc(2 * hp);
    drain("bad_start");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_ext = 1'b0;
    m_brk = 1'b0;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(2);
  endtask

  logic [7:0] tbl [12];

  initial begin : main
    longint sf;
    int     hp;
    int     r;
    logic [7:0] b;
    tbl = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74,
            8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h5A, 8'h00};

    wait_cyc(1);
    chk_en = 1'b1;
    do_reset();
    check("rst_scan_code", 32'(scan_code), 32'h00);
    check("rst_pulses",
          {25'd0, up, down, left, right, userStart, scan_valid, frame_err},
          32'd0);
    wait_cyc(1000);
    check("rst_quiet", 32'(last_pulse), 32'd0);

    good(8'hE0, 40, "e0");
    check("e0_code", 32'(scan_code), 32'hE0);
    good(8'h75, 40, "up");
    check("up_code", 32'(scan_code), 32'h75);
    check("up_cmd", 32'(last_cmd), 32'b10000);

    good(8'hE0, 30, "brk_e0");
    good(8'hF0, 30, "brk_f0");
    good(8'h75, 30, "brk_75");
    check("brk_no_cmd", 32'(last_cmd), 32'd0);
    good(8'h5A, 30, "enter");
    check("enter_cmd", 32'(last_cmd), 32'b00001);

    send_frame(8'h1C, 1'b1, 1'b0, 30, sf);
    drain("bad_par");
    check("bad_par_code", 32'(scan_code), 32'h5A);

    partial_timeout(4, 30);
    good(8'h23, 30, "right");
    check("right_cmd", 32'(last_cmd), 32'b00010);

    for (int i = 0; i < 20; i++) begin
      ps2_clk = 1'b0;
      wait_cyc(3);
      ps2_clk = 1'b1;
      wait_cyc(12);
    end
    wait_cyc(50);
    check("glitch_queue", 32'(q.size()), 32'd0);
    good(8'h1B, 30, "down");
    check("down_cmd", 32'(last_cmd), 32'b01000);

    good(8'hE0, 30, "kp_e0");
    good(8'h5A, 30, "kp_enter");
    check("kp_enter_cmd", 32'(last_cmd), 32'd0);

    clk_pulse(1'b0, 30);
    for (int i = 0; i < 4; i++) clk_pulse(1'b1, 30);
    do_reset();
    check("midrst_code", 32'(scan_code), 32'h00);
    good(8'h1D, 30, "w_up");
    check("w_up_cmd", 32'(last_cmd), 32'b10000);

    send_frame(8'h1C, 1'b0, 1'b1, 30, sf);
    drain("bad_stop");
    bad_start(30);

    for (int n = 0; n < 40; n++) begin
      hp = $urandom_range(15, 30);
      r  = $urandom_range(0, 99);
      b  = tbl[$urandom_range(0, 11)];
      if (b == 8'h00) b = 8'($urandom);
      if (r < 10) begin
        send_frame(b, 1'b1, 1'b0, hp, sf);
        drain("rnd_par");
      end else if (r < 15) begin
        send_frame(b, 1'b0, 1'b1, hp, sf);
        drain("rnd_stop");
      end else if (r < 19) begin
        partial_timeout($urandom_range(1, 10), hp);
      end else if (r < 23 && !m_ext && !m_brk) begin
        bad_start(hp);
      end else begin
        good(b, hp, "rnd");
      end
    end

    wait_cyc(100);
    check("final_queue", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
